// File: rtl/kfpga_config_pkg.sv
// Shared switch-box configuration constants and the loader state type.
// Field offsets locate each routing group inside the 264-bit config word.
package kfpga_config_pkg;

    localparam int SB_CONFIG_WIDTH = 264;
    localparam int SB_IC_SEL_W     = 3;
    localparam int SB_LE_SEL_W     = 6;

    localparam int SB_NORTH_BASE = 0;
    localparam int SB_EAST_BASE  = 30;
    localparam int SB_SOUTH_BASE = 60;
    localparam int SB_WEST_BASE  = 90;
    localparam int SB_LE_BASE    = 120;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } loader_state_e;

endpackage

// File: rtl/config_shift_reg.sv
// Word-wide bitstream shift register feeding a shadow register that only
// updates on commit, so downstream muxes never observe a partial load.
module config_shift_reg
    import kfpga_config_pkg::*;
#(
    parameter int CONFIG_WIDTH = SB_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    shift_en_i,
    input  logic                    commit_en_i,
    input  logic [WORD_WIDTH-1:0]   data_i,
    output logic [CONFIG_WIDTH-1:0] config_o
);

    logic [CONFIG_WIDTH-1:0] sreg_q;
    logic [CONFIG_WIDTH-1:0] sreg_d;
    logic [CONFIG_WIDTH-1:0] shadow_q;

    // New words enter at the top, so the first word ends up in the low bits.
    assign sreg_d = {data_i, sreg_q[CONFIG_WIDTH-1:WORD_WIDTH]};

    // The shadow captures the shifted value including the committing word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q   <= '0;
            shadow_q <= '0;
        end else begin
            if (shift_en_i) begin
                sreg_q <= sreg_d;
            end
            if (commit_en_i) begin
                shadow_q <= sreg_d;
            end
        end
    end

    assign config_o = shadow_q;

endmodule

// File: rtl/sb_config_loader.sv
// Switch-box configuration loader: frames a valid/ready bitstream into a
// full config word and commits it only when exactly NWORDS words end in cfg_last.
module sb_config_loader
    import kfpga_config_pkg::*;
#(
    parameter  int CONFIG_WIDTH = SB_CONFIG_WIDTH,
    parameter  int WORD_WIDTH   = 8,
    localparam int NWORDS       = CONFIG_WIDTH / WORD_WIDTH,
    localparam int CNT_W        = $clog2(NWORDS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [WORD_WIDTH-1:0]   cfg_data,
    input  logic                    cfg_last,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    done,
    output logic                    error,
    output logic [CNT_W-1:0]        word_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    loader_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;
    logic             commit;

    assign cfg_ready = (state_q == LOAD) && !start;
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // start overrides everything; framing is judged on each accepted word.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        commit  = 1'b0;
        if (start) begin
            state_d = LOAD;
            count_d = '0;
        end else if (accept) begin
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_IDX) begin
                if (cfg_last) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    state_d = ERROR;
                end
            end else if (cfg_last) begin
                state_d = ERROR;
            end
        end
    end

    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign word_count = count_q;

    config_shift_reg #(
        .CONFIG_WIDTH (CONFIG_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) u_shift_reg (
        .clk_i       (clock),
        .rst_i       (reset),
        .shift_en_i  (accept),
        .commit_en_i (commit),
        .data_i      (cfg_data),
        .config_o    (config_out)
    );

endmodule

// File: tb/tb_sb_config_loader.sv
// Self-checking bench for sb_config_loader: a word-list reference model
// checked every cycle, plus directed loads with literal expectations.
module tb_sb_config_loader;

    localparam int CW = 264;
    localparam int W  = 8;
    localparam int NW = CW / W;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_last = 1'b0;
    logic [W-1:0]  cfg_data = '0;
    logic          cfg_ready;
    logic          done;
    logic          error;
    logic [CW-1:0] config_out;
    logic [5:0]    word_count;

    int assertCount = 0;
    int failCount   = 0;

    logic [W-1:0]  loadWords [NW];
    logic [CW-1:0] expA;
    logic [CW-1:0] expOnes;
    logic [CW-1:0] expA5;

    // Reference model: 0 idle, 1 loading, 2 committed, 3 framing error.
    int            mState = 0;
    logic [W-1:0]  mWords [$];
    logic [CW-1:0] mCfg = '0;

    sb_config_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .config_out (config_out),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [CW-1:0] actual, input logic [CW-1:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mState = 0;
            mWords.delete();
            mCfg = '0;
        end else begin
            bit rdy;
            rdy = (mState == 1) && !start;
            if (start) begin
                mState = 1;
                mWords.delete();
            end else if (rdy && cfg_valid) begin
                mWords.push_back(cfg_data);
                if (mWords.size() == NW && cfg_last) begin
                    for (int k = 0; k < NW; k++) mCfg[k*W +: W] = mWords[k];
                    mState = 2;
                end else if (cfg_last || mWords.size() == NW) begin
                    mState = 3;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("m_ready", CW'(cfg_ready), CW'((mState == 1) && !start));
            checkOutput("m_done", CW'(done), CW'(mState == 2));
            checkOutput("m_error", CW'(error), CW'(mState == 3));
            checkOutput("m_count", CW'(word_count), CW'(mWords.size()));
            checkOutput("m_config", config_out, mCfg);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit v, input bit l, input logic [W-1:0] d);
        start = s;
        cfg_valid = v;
        cfg_last = l;
        cfg_data = d;
        tick();
    endtask

    task automatic pulseStart(input bit withValid);
        applyStimulus(1'b1, withValid, 1'b0, 8'h5A);
        start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [W-1:0] d, input bit l, input int gap);
        int tries;
        bit hs;
        tries = 0;
        hs = 1'b0;
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = d;
        cfg_last = l;
        while (!hs && tries < 64) begin
            @(negedge clock);
            hs = cfg_ready;
            @(posedge clock);
            #1;
            tries++;
        end
        assertCount++;
        if (!hs) begin
            failCount++;
            $display("[TB] FAIL handshake_timeout: got ready=0 for %0d cycles, required a handshake", tries);
        end
        cfg_valid = 1'b0;
        cfg_last = 1'b0;
        repeat (gap) tick();
    endtask

    // gapMode: 0 back-to-back, 1 alternate idle cycles, 2 random gaps.
    task automatic sendLoad(input int n, input int lastAt, input int gapMode, input int longGapAt);
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (k + 1 == longGapAt) gap = 5;
            sendWord(loadWords[k], (k + 1) == lastAt, gap);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r;
        int n;
        for (int k = 0; k < NW; k++) begin
            expA[k*W +: W]    = 8'(k + 1);
            expOnes[k*W +: W] = 8'hFF;
            expA5[k*W +: W]   = 8'hA5;
        end

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Idle after reset: valid pulses must be ignored.
        applyStimulus(0, 1, 0, 8'h33);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 1, 1, 8'h44);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("reset_config", config_out, '0);
        checkOutput("reset_done", CW'(done), '0);
        checkOutput("reset_error", CW'(error), '0);
        checkOutput("reset_ready", CW'(cfg_ready), '0);
        checkOutput("reset_count", CW'(word_count), '0);

        // Back-to-back load of 1..33.
        for (int k = 0; k < NW; k++) loadWords[k] = 8'(k + 1);
        pulseStart(0);
        sendLoad(NW, NW, 0, 0);
        checkOutput("commit_byte0", CW'(config_out[7:0]), CW'(8'h01));
        checkOutput("commit_byte1", CW'(config_out[15:8]), CW'(8'h02));
        checkOutput("commit_byte32", CW'(config_out[263:256]), CW'(8'h21));
        checkOutput("commit_full", config_out, expA);
        checkOutput("commit_done", CW'(done), CW'(1));
        checkOutput("commit_count", CW'(word_count), CW'(33));
        checkOutput("commit_ready", CW'(cfg_ready), '0);

        // DONE ignores further traffic.
        applyStimulus(0, 1, 1, 8'hEE);
        applyStimulus(0, 1, 0, 8'hEE);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("done_hold_config", config_out, expA);
        checkOutput("done_hold_done", CW'(done), CW'(1));

        // Same load with toggling valid and a long gap.
        pulseStart(0);
        sendLoad(NW, NW, 1, 20);
        checkOutput("toggle_config", config_out, expA);
        checkOutput("toggle_done", CW'(done), CW'(1));

        // Early cfg_last on word 10.
        pulseStart(0);
        sendLoad(10, 10, 0, 0);
        checkOutput("early_error", CW'(error), CW'(1));
        checkOutput("early_done", CW'(done), '0);
        checkOutput("early_config", config_out, expA);

        for (int k = 0; k < NW; k++) loadWords[k] = 8'hFF;
        pulseStart(0);
        sendLoad(NW, NW, 0, 0);
        checkOutput("ones_config", config_out, expOnes);
        checkOutput("ones_error", CW'(error), '0);

        // Missing cfg_last on word 33.
        for (int k = 0; k < NW; k++) loadWords[k] = 8'(k * 3 + 7);
        pulseStart(0);
        sendLoad(NW, 0, 0, 0);
        checkOutput("nolast_error", CW'(error), CW'(1));
        checkOutput("nolast_config", config_out, expOnes);

        // Restart mid-load, with a word offered during the restart.
        for (int k = 0; k < NW; k++) loadWords[k] = 8'h3C;
        pulseStart(0);
        sendLoad(12, 0, 0, 0);
        pulseStart(1);
        for (int k = 0; k < NW; k++) loadWords[k] = 8'hA5;
        sendLoad(NW, NW, 0, 0);
        checkOutput("restart_config", config_out, expA5);
        checkOutput("restart_done", CW'(done), CW'(1));
        checkOutput("restart_count", CW'(word_count), CW'(33));

        // Asynchronous reset in the middle of a load.
        pulseStart(0);
        sendLoad(7, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_config", config_out, '0);
        checkOutput("async_reset_done", CW'(done), '0);
        checkOutput("async_reset_ready", CW'(cfg_ready), '0);
        checkOutput("async_reset_count", CW'(word_count), '0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Randomized loads checked by the model.
        for (int it = 0; it < 14; it++) begin
            for (int k = 0; k < NW; k++) loadWords[k] = 8'($urandom);
            pulseStart(bit'($urandom_range(0, 1)));
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                sendLoad(NW, NW, 2, 0);
            end else if (r < 8) begin
                n = int'($urandom_range(1, NW - 1));
                sendLoad(n, n, 2, 0);
            end else if (r == 8) begin
                sendLoad(NW, 0, 2, 0);
            end else begin
                sendLoad(int'($urandom_range(1, 20)), 0, 2, 0);
            end
            repeat (int'($urandom_range(0, 3))) applyStimulus(0, bit'($urandom_range(0, 1)), 0, 8'($urandom));
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
